// File: rtl/i2c_pkg.sv
// Shared I2C constants and the target FSM state type.
package i2c_pkg;
  localparam int I2C_ADDR_WIDTH = 7;
  localparam int I2C_DATA_WIDTH = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITE_ACK = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_ACK  = 3'd6,
    ST_IGNORE    = 3'd7
  } i2c_target_state_t;
endpackage

// File: rtl/i2c_line_filter.sv
// 2-flop synchronizer plus stability filter with registered rise/fall pulses.
// Pin-to-pulse latency is 2+FILTER_LEN clocks; no flow control, free-running.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic i_line,
  output logic o_line,
  output logic o_rise,
  output logic o_fall
);
  localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;

  // r_cnt counts consecutive synchronized samples that disagree with o_line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      o_line <= 1'b1;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      if (r_sync[1] == o_line) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
        o_line <= r_sync[1];
        o_rise <= r_sync[1];
        o_fall <= ~r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/i2c_target.sv
// Fixed-address I2C target: START/STOP detect, address ACK, byte write delivery, byte read service.
// Pulses appear 2+FILTER_LEN clocks after the causing pin edge; no clock stretching, tx_data must be ready by the next scl fall.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = I2C_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = I2C_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h42,
  parameter int                    FILTER_LEN  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  scl,
  inout  tri                    sda,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_req,
  output logic                  rd_nack,
  output logic                  busy
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_last_bit;
  logic [DATA_WIDTH-1:0] w_shift_in;

  i2c_target_state_t     r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_sda_low;
  logic                  r_rw;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clock  (clock),
    .reset  (reset),
    .i_line (scl),
    .o_line (w_scl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clock  (clock),
    .reset  (reset),
    .i_line (sda),
    .o_line (w_sda),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  assign w_start    = w_sda_fall & w_scl;
  assign w_stop     = w_sda_rise & w_scl;
  assign w_shift_in = {r_shift[DATA_WIDTH-2:0], w_sda};
  assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign sda        = r_sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_sda_low <= 1'b0;
      r_rw      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      rd_nack   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      rd_nack  <= 1'b0;
      // Bus conditions outrank any scl edge seen on the same clock
      if (w_start || w_stop) begin
        r_state   <= w_start ? ST_ADDR : ST_IDLE;
        r_bit_cnt <= '0;
        r_sda_low <= 1'b0;
        busy      <= 1'b0;
      end else if (w_scl_rise) begin
        case (r_state)
          ST_ADDR: begin
            r_shift   <= w_shift_in;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (w_last_bit) begin
              r_bit_cnt <= '0;
              if (w_shift_in[DATA_WIDTH-1 -: ADDR_WIDTH] == TARGET_ADDR) begin
                r_state <= ST_ADDR_ACK;
                busy    <= 1'b1;
                r_rw    <= w_shift_in[0];
                tx_req  <= w_shift_in[0];
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
          ST_WRITE: begin
            r_shift   <= w_shift_in;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (w_last_bit) begin
              r_bit_cnt <= '0;
              rx_data   <= w_shift_in;
              rx_valid  <= 1'b1;
              r_state   <= ST_WRITE_ACK;
            end
          end
          ST_READ: r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          ST_READ_ACK: begin
            if (w_sda == ACK) begin
              tx_req <= 1'b1;
            end else begin
              rd_nack <= 1'b1;
              r_state <= ST_IGNORE;
            end
          end
          default: ;
        endcase
      end else if (w_scl_fall) begin
        case (r_state)
          // First fall starts the ACK drive, the second one closes the ACK bit
          ST_ADDR_ACK: begin
            if (!r_sda_low) begin
              r_sda_low <= 1'b1;
            end else if (r_rw) begin
              r_shift   <= tx_data;
              r_sda_low <= ~tx_data[DATA_WIDTH-1];
              r_state   <= ST_READ;
            end else begin
              r_sda_low <= 1'b0;
              r_state   <= ST_WRITE;
            end
          end
          ST_WRITE_ACK: begin
            if (!r_sda_low) begin
              r_sda_low <= 1'b1;
            end else begin
              r_sda_low <= 1'b0;
              r_state   <= ST_WRITE;
            end
          end
          ST_READ: begin
            if (r_bit_cnt == CNT_W'(DATA_WIDTH)) begin
              r_sda_low <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= ST_READ_ACK;
            end else begin
              r_shift   <= {r_shift[DATA_WIDTH-2:0], r_shift[DATA_WIDTH-1]};
              r_sda_low <= ~r_shift[DATA_WIDTH-2];
            end
          end
          ST_READ_ACK: begin
            r_shift   <= tx_data;
            r_sda_low <= ~tx_data[DATA_WIDTH-1];
            r_state   <= ST_READ;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// Bench: bit-banged I2C controller plus event scoreboard for i2c_target.
module tb_i2c_target;
  import i2c_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       scl;
  logic       ctl_sda_low;
  wire        sda_w;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_req, rd_nack, busy;

  pullup (sda_w);
  assign sda_w = ctl_sda_low ? 1'b0 : 1'bz;

  i2c_target #(.TARGET_ADDR(7'h42), .FILTER_LEN(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda_w),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rd_nack  (rd_nack),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int q        = 10;

  // Scoreboard state: what the target is allowed/required to emit
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];
  int         exp_txreq = 0;
  int         exp_nack  = 0;
  logic [7:0] model_rx  = 8'h00;
  int         n_rxv = 0, n_txr = 0, n_nack = 0;

  logic [7:0] wbuf [0:3];
  logic [7:0] rbuf [0:3];
  logic [7:0] rd_got [0:3];
  logic       last_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Compare process: every output pulse must be one the model expects
  initial forever begin
    @(negedge clock);
    if (reset) begin
      model_rx = 8'h00;
      chk("reset_rx_valid", rx_valid, 1'b0);
      chk("reset_tx_req", tx_req, 1'b0);
      chk("reset_rd_nack", rd_nack, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_rx_data", rx_data, 8'h00);
    end else begin
      if (rx_valid) begin
        n_rxv++;
        if (exp_rx.size() == 0) chk("rx_valid_expected", rx_valid, 1'b0);
        else begin
          model_rx = exp_rx.pop_front();
          chk("rx_data", rx_data, model_rx);
        end
      end else begin
        chk("rx_data_hold", rx_data, model_rx);
      end
      if (tx_req) begin
        n_txr++;
        if (exp_txreq == 0) chk("tx_req_expected", tx_req, 1'b0);
        else exp_txreq--;
        if (tx_q.size() > 0) tx_data = tx_q.pop_front();
      end
      if (rd_nack) begin
        n_nack++;
        if (exp_nack == 0) chk("rd_nack_expected", rd_nack, 1'b0);
        else exp_nack--;
      end
    end
  end

  // One SCL bit: data set while scl low, sampled mid-high
  task automatic bit_xfer(input logic b, output logic s);
    ctl_sda_low = !b;
    tick(q);
    scl = 1'b1;
    tick(q);
    s = sda_w;
    last_busy = busy;
    tick(q);
    scl = 1'b0;
    tick(q);
  endtask

  task automatic bus_start(input int hold);
    if (scl == 1'b0) begin
      ctl_sda_low = 1'b0;
      tick(q);
      scl = 1'b1;
      tick(q);
    end
    ctl_sda_low = 1'b1;
    tick(hold);
    scl = 1'b0;
    tick(q);
  endtask

  task automatic bus_stop();
    ctl_sda_low = 1'b1;
    tick(q);
    scl = 1'b1;
    tick(q);
    ctl_sda_low = 1'b0;
    tick(q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack_bit);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(ack_bit, s);
  endtask

  task automatic write_txn(input logic [6:0] a, input int n, input int hold);
    logic ack;
    logic match;
    match = (a == 7'h42);
    bus_start(hold);
    send_byte({a, 1'b0}, ack);
    chk("wr_addr_ack", ack, match ? ACK : NACK);
    chk("wr_busy_addr", last_busy, match);
    if (match) begin
      for (int i = 0; i < n; i++) begin
        exp_rx.push_back(wbuf[i]);
        send_byte(wbuf[i], ack);
        chk("wr_data_ack", ack, ACK);
        chk("wr_busy_data", last_busy, 1'b1);
      end
    end
    bus_stop();
    tick(8);
    chk("wr_busy_after_stop", busy, 1'b0);
    chk("wr_rx_drained", exp_rx.size(), 0);
  endtask

  task automatic read_txn(input logic [6:0] a, input int n);
    logic ack;
    logic match;
    logic [7:0] d;
    match = (a == 7'h42);
    if (match) begin
      for (int i = 0; i < n; i++) tx_q.push_back(rbuf[i]);
      exp_txreq += 1;
    end
    bus_start(q);
    send_byte({a, 1'b1}, ack);
    chk("rd_addr_ack", ack, match ? ACK : NACK);
    if (match) begin
      for (int i = 0; i < n; i++) begin
        if (i == n - 1) exp_nack += 1;
        else exp_txreq += 1;
        recv_byte(d, (i == n - 1) ? NACK : ACK);
        rd_got[i] = d;
        chk("rd_byte", d, rbuf[i]);
      end
      chk("rd_busy_before_stop", busy, 1'b1);
      chk("rd_sda_released", sda_w, 1'b1);
    end
    bus_stop();
    tick(8);
    chk("rd_busy_after_stop", busy, 1'b0);
    chk("rd_txreq_drained", exp_txreq, 0);
    chk("rd_nack_drained", exp_nack, 0);
    chk("rd_txq_drained", tx_q.size(), 0);
  endtask

  initial begin
    int b_rxv, b_txr, b_nack;
    logic s;
    logic [7:0] ab;
    logic [6:0] a;
    int n;

    reset = 1'b1;
    scl = 1'b1;
    ctl_sda_low = 1'b0;
    tx_data = 8'h00;
    tick(3);
    chk("init_sda_z", sda_w, 1'b1);
    chk("init_rx_data", rx_data, 8'h00);
    chk("init_busy", busy, 1'b0);
    reset = 1'b0;
    tick(10);

    // Write A5, 3C to own address
    b_rxv = n_rxv;
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    write_txn(7'h42, 2, q);
    chk("t1_rx_count", n_rxv - b_rxv, 2);
    chk("t1_rx_last", rx_data, 8'h3C);

    // Foreign address: no ACK, no data
    b_rxv = n_rxv;
    wbuf[0] = 8'h11;
    write_txn(7'h43, 1, q);
    chk("t2_rx_count", n_rxv - b_rxv, 0);
    chk("t2_rx_hold", rx_data, 8'h3C);

    // Read 96 (ACK) then 0F (NACK)
    b_txr = n_txr; b_nack = n_nack;
    rbuf[0] = 8'h96; rbuf[1] = 8'h0F;
    read_txn(7'h42, 2);
    chk("t3_byte0", rd_got[0], 8'b1001_0110);
    chk("t3_byte1", rd_got[1], 8'b0000_1111);
    chk("t3_txreq_count", n_txr - b_txr, 2);
    chk("t3_nack_count", n_nack - b_nack, 1);

    // Repeated START part-way through a write byte
    b_rxv = n_rxv;
    bus_start(q);
    send_byte({7'h42, 1'b0}, s);
    chk("t4_addr_ack", s, ACK);
    ab = 8'hF0;
    for (int i = 7; i >= 4; i--) bit_xfer(ab[i], s);
    rbuf[0] = 8'h5A;
    read_txn(7'h42, 1);
    chk("t4_rx_count", n_rxv - b_rxv, 0);
    chk("t4_read_byte", rd_got[0], 8'h5A);

    // One-clock sda glitch with scl high must not look like START
    ctl_sda_low = 1'b1;
    tick(1);
    ctl_sda_low = 1'b0;
    tick(10);
    scl = 1'b0;
    tick(q);
    send_byte({7'h42, 1'b0}, s);
    chk("t5_glitch_no_ack", s, NACK);
    chk("t5_glitch_busy", last_busy, 1'b0);
    bus_stop();
    tick(8);
    // Five-clock low before scl falls is a real START
    wbuf[0] = 8'hC3;
    write_txn(7'h42, 1, 5);
    chk("t5_rx_last", rx_data, 8'hC3);

    // Reset while the address ACK is being driven
    bus_start(q);
    ab = {7'h42, 1'b0};
    for (int i = 7; i >= 0; i--) bit_xfer(ab[i], s);
    ctl_sda_low = 1'b0;
    tick(q);
    chk("t6_ack_driven", sda_w, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_sda_released", sda_w, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_rx_data", rx_data, 8'h00);
    chk("t6_pulses", {rx_valid, tx_req, rd_nack}, 3'b000);
    tick(3);
    reset = 1'b0;
    scl = 1'b1;
    tick(2 * q);
    wbuf[0] = 8'h7E; wbuf[1] = 8'h81;
    write_txn(7'h42, 2, q);
    chk("t6_rx_after_reset", rx_data, 8'h81);

    // Randomized mix of reads/writes, own and foreign addresses
    for (int t = 0; t < 20; t++) begin
      q = $urandom_range(10, 12);
      a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h42;
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        wbuf[i] = 8'($urandom);
        rbuf[i] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) read_txn(a, n);
      else write_txn(a, n, q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
